// File: rtl/req_gnt_window_mon.sv
// req_gnt_window_mon
//   Checks that each channel's grant arrives within a latched [min_lat, max_lat]
//   window after its request. Reports events as registered one-cycle pulses, a
//   sticky error flag, a saturating error count and the latency of legal grants.
//
// Ports
//   clk, rst_n          clock, async active-low reset (deassert synchronised)
//   en                  monitor enable; low forces every channel to IDLE
//   clr                 synchronous clear of err_sticky / err_cnt
//   min_lat, max_lat    legal latency window, latched at request acceptance
//   req, gnt            per-channel handshake being observed
//   done, lat           legal grant pulse and its latency (lat holds until next done)
//   err_early/timeout/spurious/overlap/cfg   per-channel error pulses
//   err_sticky, err_cnt summary of all error pulses
//
// Per-channel FSM
//   state | meaning
//   IDLE  | no outstanding request
//   WAIT  | request accepted, counting latency against latched window
module req_gnt_window_mon #(
  parameter int NUM_CH = 2,
  parameter int LAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [LAT_W-1:0]        min_lat,
  input  logic [LAT_W-1:0]        max_lat,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH-1:0]       gnt,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*LAT_W-1:0] lat,
  output logic [NUM_CH-1:0]       err_early,
  output logic [NUM_CH-1:0]       err_timeout,
  output logic [NUM_CH-1:0]       err_spurious,
  output logic [NUM_CH-1:0]       err_overlap,
  output logic [NUM_CH-1:0]       err_cfg,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        err_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int ERR_N = 5 * NUM_CH;
  localparam int POP_W = $clog2(ERR_N + 1);
  localparam int SUM_W = CNT_W + POP_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  // Assertion is immediate; release is delayed two edges so no flop sees a
  // deassertion close to the clock edge.
  logic rst_meta, rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  state_t             state_q [NUM_CH];
  state_t             state_d [NUM_CH];
  logic [LAT_W:0]     cnt_q   [NUM_CH];
  logic [LAT_W:0]     cnt_d   [NUM_CH];
  logic [LAT_W-1:0]   min_q   [NUM_CH];
  logic [LAT_W-1:0]   min_d   [NUM_CH];
  logic [LAT_W-1:0]   max_q   [NUM_CH];
  logic [LAT_W-1:0]   max_d   [NUM_CH];

  logic [NUM_CH-1:0]       done_d, early_d, timeout_d, spur_d, ovl_d, cfg_d;
  logic [NUM_CH*LAT_W-1:0] lat_d;
  logic                    cfg_ok;

  assign cfg_ok = (min_lat <= max_lat);

  always_comb begin
    logic [LAT_W:0] l_cur;
    logic           term;
    logic           accept;
    l_cur     = '0;
    term      = 1'b0;
    accept    = 1'b0;
    done_d    = '0;
    early_d   = '0;
    timeout_d = '0;
    spur_d    = '0;
    ovl_d     = '0;
    cfg_d     = '0;
    lat_d     = lat;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      min_d[c]   = min_q[c];
      max_d[c]   = max_q[c];
      // cnt_q holds the latency of the previous edge, so this edge's L is one more.
      l_cur      = cnt_q[c] + 1'b1;
      term       = 1'b0;
      accept     = 1'b0;
      if (!en) begin
        state_d[c] = IDLE;
        cnt_d[c]   = '0;
      end else begin
        case (state_q[c])
          IDLE: begin
            if (gnt[c]) spur_d[c] = 1'b1;
            if (req[c]) accept = 1'b1;
          end
          WAIT: begin
            cnt_d[c] = l_cur;
            // Timeout wins over a grant on the max+1 edge.
            if (l_cur > {1'b0, max_q[c]}) begin
              timeout_d[c] = 1'b1;
              term         = 1'b1;
            end else if (gnt[c]) begin
              term = 1'b1;
              if (l_cur < {1'b0, min_q[c]}) begin
                early_d[c] = 1'b1;
              end else begin
                done_d[c]                 = 1'b1;
                lat_d[c*LAT_W +: LAT_W]   = l_cur[LAT_W-1:0];
              end
            end
            if (term) state_d[c] = IDLE;
            if (req[c]) begin
              if (term) accept = 1'b1;
              else      ovl_d[c] = 1'b1;
            end
          end
          default: state_d[c] = IDLE;
        endcase
        if (accept) begin
          if (cfg_ok) begin
            state_d[c] = WAIT;
            cnt_d[c]   = '0;
            min_d[c]   = min_lat;
            max_d[c]   = max_lat;
          end else begin
            cfg_d[c] = 1'b1;
          end
        end
      end
    end
  end

  logic [ERR_N-1:0] err_all;
  logic [POP_W-1:0] err_pop;
  logic [SUM_W-1:0] cnt_sum;

  assign err_all = {early_d, timeout_d, spur_d, ovl_d, cfg_d};

  always_comb begin
    err_pop = '0;
    for (int i = 0; i < ERR_N; i++) err_pop = err_pop + POP_W'(err_all[i]);
    cnt_sum = SUM_W'(err_cnt) + SUM_W'(err_pop);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        min_q[c]   <= '0;
        max_q[c]   <= '0;
      end
      done         <= '0;
      lat          <= '0;
      err_early    <= '0;
      err_timeout  <= '0;
      err_spurious <= '0;
      err_overlap  <= '0;
      err_cfg      <= '0;
      err_sticky   <= 1'b0;
      err_cnt      <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        min_q[c]   <= min_d[c];
        max_q[c]   <= max_d[c];
      end
      done         <= done_d;
      lat          <= lat_d;
      err_early    <= early_d;
      err_timeout  <= timeout_d;
      err_spurious <= spur_d;
      err_overlap  <= ovl_d;
      err_cfg      <= cfg_d;
      // clr beats same-cycle errors: their pulses still fire but are not counted.
      if (clr) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end else begin
        if (|err_all) err_sticky <= 1'b1;
        err_cnt <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
      end
    end
  end

endmodule
